// File: rtl/router_pkg.sv
// Shared definitions for the 5-port NoC router: port directions, error bit indices
// and the one-hot grant encodings used by the output-port arbiters.
package router_pkg;

  localparam int unsigned NUM_DIRS = 5;
  localparam int unsigned FLIT_W   = 32;

  typedef enum logic [2:0] {
    DIR_N,
    DIR_E,
    DIR_W,
    DIR_S,
    DIR_L
  } dir_e;

  localparam int unsigned ERR_MULTI_GRANT = 0;
  localparam int unsigned ERR_EMPTY_READ  = 1;

  // Arbiter grant states; bit position matches dir_e.
  typedef enum logic [NUM_DIRS-1:0] {
    StIdle = 5'b00000,
    StGntN = 5'b00001,
    StGntE = 5'b00010,
    StGntW = 5'b00100,
    StGntS = 5'b01000,
    StGntL = 5'b10000
  } arb_state_e;

  function automatic logic multi_hot(logic [NUM_DIRS-1:0] v);
    return $countones(v) > 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Flit storage: one synchronous write port, one combinational read port, no reset.
module fifo_mem #(
  parameter int unsigned  DATA_W = 32,
  parameter int unsigned  DEPTH  = 4,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/router_input_fifo.sv
// Router input-port buffer: DRTS/CTS write handshake into a small first-word
// fall-through FIFO, popped by any output-arbiter grant, with sticky error flags.
module router_input_fifo
  import router_pkg::*;
#(
  parameter int unsigned  DATA_W = FLIT_W,
  parameter int unsigned  DEPTH  = 4,
  localparam int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              DRTS,
  input  logic [DATA_W-1:0] Data_in,
  output logic              CTS,
  input  logic              read_en_N,
  input  logic              read_en_E,
  input  logic              read_en_W,
  input  logic              read_en_S,
  input  logic              read_en_L,
  output logic [DATA_W-1:0] Data_out,
  output logic              empty,
  output logic              full,
  output logic [PTR_W:0]    count,
  output logic [1:0]        err
);

  localparam logic [PTR_W-1:0] PtrOne  = 1;
  localparam logic [PTR_W:0]   CntOne  = 1;
  localparam logic [PTR_W:0]   CntFull = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]      count_q;
  logic                cts_q;
  logic [1:0]          err_q;
  logic [NUM_DIRS-1:0] grants;
  logic                any_grant, multi_grant;
  logic                wr_en, rd_en;
  logic                is_empty, is_full;

  always_comb begin
    grants                 = '0;
    grants[int'(DIR_N)]    = read_en_N;
    grants[int'(DIR_E)]    = read_en_E;
    grants[int'(DIR_W)]    = read_en_W;
    grants[int'(DIR_S)]    = read_en_S;
    grants[int'(DIR_L)]    = read_en_L;
    any_grant   = |grants;
    multi_grant = multi_hot(grants);
    is_empty    = (count_q == '0);
    is_full     = (count_q == CntFull);
    // CTS is only ever high for one cycle, so a write never lands on a full buffer.
    wr_en       = DRTS & cts_q;
    rd_en       = any_grant & ~is_empty;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cts_q    <= 1'b0;
      err_q    <= '0;
    end else begin
      cts_q <= DRTS & ~cts_q & ~is_full;
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + PtrOne;
      end
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
      end
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + CntOne;
        2'b01:   count_q <= count_q - CntOne;
        default: count_q <= count_q;
      endcase
      err_q[ERR_MULTI_GRANT] <= err_q[ERR_MULTI_GRANT] | multi_grant;
      err_q[ERR_EMPTY_READ]  <= err_q[ERR_EMPTY_READ] | (any_grant & is_empty);
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata (Data_in),
    .raddr (rd_ptr_q),
    .rdata (Data_out)
  );

  assign CTS   = cts_q;
  assign empty = is_empty;
  assign full  = is_full;
  assign count = count_q;
  assign err   = err_q;

endmodule
